ps2_frame_receiver: RTL and testbench

- Upstream stage of the keyboard message decoder.
- Samples the raw PS/2 clock and data lines from the keyboard connector and deserialises 11-bit frames into scan-code bytes.
- Strips the 0xF0 (release) and 0xE0 (extended) prefix bytes and turns them into one-cycle flag pulses.
- Presents each remaining byte with a one-cycle latch pulse to the decoder.

---
 rtl/ps2_frame_receiver.sv | 187 ++++++++++++++++++
 tb/tb_ps2_frame_receiver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: synchronises and filters the raw PS/2 clock/data lines,
// deserialises 11-bit frames (start, 8 data LSB first, odd parity, stop) and
// turns them into one-cycle pulses: message_latch for ordinary scan codes,
// release_key for 0xF0, extended_code for 0xE0, frame_error for bad frames.
// Optional feature: define PS2_TIMEOUT_EN to abort frames that stall mid-way
// for TIMEOUT_CYCLES clk cycles.
module ps2_frame_receiver #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] message_out,
  output logic       message_latch,
  output logic       release_key,
  output logic       extended_code,
  output logic       frame_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_clk_sync;
  logic [1:0]            r_data_sync;
  logic [FILTER_LEN-1:0] r_clk_hist;
  logic                  r_clk_filt;
  logic                  w_filt_next;
  logic                  w_fe;
  logic                  w_data;
  logic [2:0]            r_bit_cnt;
  logic [7:0]            r_shift;
  logic                  r_parity;
  logic                  w_stop_eval;
  logic                  w_frame_ok;
  logic                  w_timeout;

  // Two-flop synchronisers; both lines idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
    end
  end

  // Sample history of the synchronised clock and the filtered level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_hist <= '1;
      r_clk_filt <= 1'b1;
    end else begin
      r_clk_hist <= {r_clk_hist[FILTER_LEN-2:0], r_clk_sync[1]};
      r_clk_filt <= w_filt_next;
    end
  end

  // Filtered level flips only once the whole history agrees.
  always_comb begin
    w_filt_next = r_clk_filt;
    if (r_clk_hist == '0) begin
      w_filt_next = 1'b0;
    end else if (r_clk_hist == '1) begin
      w_filt_next = 1'b1;
    end
  end

  assign w_fe        = r_clk_filt & ~w_filt_next;
  assign w_data      = r_data_sync[1];
  assign w_stop_eval = w_fe && (r_state == S_STOP);
  assign w_frame_ok  = w_data && (^{r_shift, r_parity});

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] r_idle_cnt;

  // Idle counter: cleared by every edge and while idle, saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (w_fe || (r_state == S_IDLE)) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != IDLE_W'(TIMEOUT_CYCLES)) begin
      r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    end
  end

  assign w_timeout = (r_state != S_IDLE) && !w_fe &&
                     (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES));
`else
  // No idle counter: a truncated frame waits for further clock edges.
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: advance one field per falling edge.
  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = S_IDLE;
    end else if (w_fe) begin
      unique case (r_state)
        S_IDLE:   if (!w_data) w_state_next = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_next = S_PARITY;
        S_PARITY: w_state_next = S_STOP;
        S_STOP:   w_state_next = S_IDLE;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // Frame datapath: bit counter, data shift register and parity bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
    end else if (w_timeout) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_fe) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_data) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
          end
        end
        S_DATA: begin
          r_shift[r_bit_cnt] <= w_data;
          r_bit_cnt          <= r_bit_cnt + 3'd1;
        end
        S_PARITY: r_parity <= w_data;
        default:  ;
      endcase
    end
  end

  // Registered outputs: at most one pulse per frame, one cycle after the stop edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      message_out   <= '0;
      message_latch <= 1'b0;
      release_key   <= 1'b0;
      extended_code <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      message_latch <= 1'b0;
      release_key   <= 1'b0;
      extended_code <= 1'b0;
      frame_error   <= 1'b0;
      if (w_timeout) begin
        frame_error <= 1'b1;
      end else if (w_stop_eval) begin
        if (!w_frame_ok) begin
          frame_error <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          release_key <= 1'b1;
        end else if (r_shift == 8'hE0) begin
          extended_code <= 1'b1;
        end else begin
          message_out   <= r_shift;
          message_latch <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Testbench for ps2_frame_receiver: table of whole frames with expected pulse
// kind and message_out, plus hand sequences for glitches, truncated frames and
// mid-frame reset. Build with +define+PS2_TIMEOUT_EN to exercise the timeout.
module tb_ps2_frame_receiver;

  localparam int unsigned TO = 300;
  localparam int K_LATCH = 0;
  localparam int K_REL   = 1;
  localparam int K_EXT   = 2;
  localparam int K_ERR   = 3;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] message_out;
  logic       message_latch;
  logic       release_key;
  logic       extended_code;
  logic       frame_error;

  ps2_frame_receiver #(
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .message_out  (message_out),
    .message_latch(message_latch),
    .release_key  (release_key),
    .extended_code(extended_code),
    .frame_error  (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Pulse monitor (sampled on the falling clk edge).
  int n_latch = 0, n_rel = 0, n_ext = 0, n_err = 0;
  int n_overlap = 0, n_stretch = 0, last_pulse_cyc = 0;
  logic [3:0] prev_p = '0;
  always @(negedge clk) begin
    logic [3:0] p;
    p = {frame_error, extended_code, release_key, message_latch};
    if (!rst) begin
      if (p[0]) n_latch++;
      if (p[1]) n_rel++;
      if (p[2]) n_ext++;
      if (p[3]) n_err++;
      if (p != 4'b0) last_pulse_cyc = cyc;
      if ((int'(p[0]) + int'(p[1]) + int'(p[2]) + int'(p[3])) > 1) n_overlap++;
      if ((p & prev_p) != 4'b0) n_stretch++;
    end
    prev_p = p;
  end

  int n_vec = 0;
  int n_bad = 0;
  int s_l, s_r, s_e, s_f;
  int fall_cyc;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic snap();
    s_l = n_latch; s_r = n_rel; s_e = n_ext; s_f = n_err;
  endtask

  task automatic expect_pulses(input string tag, input int el, input int er,
                               input int ee, input int ef, input logic [7:0] em);
    check({tag, "_latch"}, n_latch - s_l, el);
    check({tag, "_release"}, n_rel - s_r, er);
    check({tag, "_extended"}, n_ext - s_e, ee);
    check({tag, "_error"}, n_err - s_f, ef);
    check({tag, "_msg"}, int'(message_out), int'(em));
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par,
                                             input bit stop);
    logic par;
    par = (~^d) ^ bad_par;
    return {stop, par, d, 1'b0};
  endfunction

  // Bits lo..hi of a frame; data changes only while ps2_clk is high.
  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (10) @(negedge clk);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
      ps2_data = ~f[i];
      repeat (10) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic glitch_clk(input int len);
    @(negedge clk);
    ps2_clk = 1'b0;
    repeat (len) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         stop;
    int         kind;
    logic [7:0] exp_msg;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat;
    logic [10:0] f;

    vecs[0]  = '{8'hF0, 1'b0, 1'b1, K_REL,   8'h00};
    vecs[1]  = '{8'h1C, 1'b0, 1'b1, K_LATCH, 8'h1C};
    vecs[2]  = '{8'hE0, 1'b0, 1'b1, K_EXT,   8'h1C};
    vecs[3]  = '{8'hF0, 1'b0, 1'b1, K_REL,   8'h1C};
    vecs[4]  = '{8'h75, 1'b0, 1'b1, K_LATCH, 8'h75};
    vecs[5]  = '{8'h1C, 1'b1, 1'b1, K_ERR,   8'h75};
    vecs[6]  = '{8'h1C, 1'b0, 1'b0, K_ERR,   8'h75};
    vecs[7]  = '{8'hE1, 1'b0, 1'b1, K_LATCH, 8'hE1};
    vecs[8]  = '{8'hAA, 1'b0, 1'b1, K_LATCH, 8'hAA};
    vecs[9]  = '{8'hFA, 1'b0, 1'b1, K_LATCH, 8'hFA};
    vecs[10] = '{8'h00, 1'b0, 1'b1, K_LATCH, 8'h00};
    vecs[11] = '{8'hFF, 1'b0, 1'b1, K_LATCH, 8'hFF};

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_msg", int'(message_out), 0);
    check("reset_pulses",
          int'({frame_error, extended_code, release_key, message_latch}), 0);
    rst = 1'b0;

    snap();
    repeat (1000) @(negedge clk);
    expect_pulses("idle", 0, 0, 0, 0, 8'h00);

    for (int v = 0; v < 12; v++) begin
      snap();
      send_bits(make_frame(vecs[v].data, vecs[v].bad_par, vecs[v].stop), 0, 10);
      repeat (40) @(negedge clk);
      expect_pulses($sformatf("vec%0d", v),
                    int'(vecs[v].kind == K_LATCH), int'(vecs[v].kind == K_REL),
                    int'(vecs[v].kind == K_EXT), int'(vecs[v].kind == K_ERR),
                    vecs[v].exp_msg);
      lat = last_pulse_cyc - fall_cyc;
      n_vec++;
      if (lat < 4 || lat > 12) begin
        n_bad++;
        $display("FAIL vec%0d_latency: got %0d cycles after stop edge, expected 4..12", v, lat);
      end
    end

    // Short ps2_clk glitches (1 and FILTER_LEN-1 cycles) and a lone edge with data high.
    snap();
    glitch_clk(1);
    glitch_clk(3);
    send_bits(11'h7FF, 0, 0);
    repeat (40) @(negedge clk);
    expect_pulses("glitch", 0, 0, 0, 0, 8'hFF);
    snap();
    send_bits(make_frame(8'h1C, 1'b0, 1'b1), 0, 10);
    repeat (40) @(negedge clk);
    expect_pulses("after_glitch", 1, 0, 0, 0, 8'h1C);

    // Truncated frame: start plus four data bits, then a long quiet bus.
    f = make_frame(8'h29, 1'b0, 1'b1);
    snap();
    send_bits(f, 0, 4);
`ifdef PS2_TIMEOUT_EN
    repeat (TO + 10) @(negedge clk);
    expect_pulses("timeout", 0, 0, 0, 1, 8'h1C);
    snap();
    send_bits(f, 0, 10);
`else
    repeat (TO + 10) @(negedge clk);
    expect_pulses("stall", 0, 0, 0, 0, 8'h1C);
    snap();
    send_bits(f, 5, 10);
`endif
    repeat (40) @(negedge clk);
    expect_pulses("after_trunc", 1, 0, 0, 0, 8'h29);

    // Reset in the middle of a frame: no pulse, next frame accepted.
    snap();
    send_bits(make_frame(8'h75, 1'b0, 1'b1), 0, 3);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    expect_pulses("midrst", 0, 0, 0, 0, 8'h00);
    snap();
    send_bits(make_frame(8'h75, 1'b0, 1'b1), 0, 10);
    repeat (40) @(negedge clk);
    expect_pulses("after_rst", 1, 0, 0, 0, 8'h75);

    check("overlap_cycles", n_overlap, 0);
    check("stretched_pulses", n_stretch, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
